// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's instruction-fetch (imem) and data (dmem)
// request ports onto one shared memory port.
//
// Handshake (all three ports): a requester raises valid and holds valid,
// instr, addr, wdata and wstrb stable until it sees a one-cycle ready;
// rdata is valid in that ready cycle. wstrb == 0 means read.
//
// Arbitration: dmem has fixed priority, but once dmem has been granted
// starve_limit times in a row while imem was waiting, imem wins the next
// contended arbitration. A transaction that does not finish in its first
// cycle locks the port to its requester until memory_ready (or until the
// requester abandons it by dropping valid).
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   imem_*               instruction-fetch requester port
//   dmem_*               data requester port
//   memory_*             shared memory port (request out, rdata/ready in)
//   dbg_owner            current owner register (0 none, 1 imem, 2 dmem)
//   dbg_scnt             starvation counter
module mem_arbiter #(
    parameter int unsigned starve_limit = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic [1:0]  dbg_owner,
    output logic [3:0]  dbg_scnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = starve_limit[3:0];

    owner_t      r_owner;
    logic [3:0]  r_scnt;
    owner_t      w_sel;
    logic        w_fwd_valid;

    // Selection: a locked owner keeps the port; otherwise arbitrate
    // combinationally so an idle-cycle request reaches memory at once.
    always_comb begin
        w_sel = OWN_NONE;
        if (r_owner != OWN_NONE) begin
            w_sel = r_owner;
        end else if (imem_valid && dmem_valid) begin
            w_sel = (r_scnt >= LIMIT) ? OWN_IMEM : OWN_DMEM;
        end else if (imem_valid) begin
            w_sel = OWN_IMEM;
        end else if (dmem_valid) begin
            w_sel = OWN_DMEM;
        end
    end

    // Forward the whole request of exactly one requester, never a mix.
    always_comb begin
        w_fwd_valid  = 1'b0;
        memory_instr = 1'b0;
        memory_addr  = 32'd0;
        memory_wdata = 32'd0;
        memory_wstrb = 4'd0;
        case (w_sel)
            OWN_IMEM: begin
                w_fwd_valid  = imem_valid;
                memory_instr = imem_instr;
                memory_addr  = imem_addr;
                memory_wdata = imem_wdata;
                memory_wstrb = imem_wstrb;
            end
            OWN_DMEM: begin
                w_fwd_valid  = dmem_valid;
                memory_instr = dmem_instr;
                memory_addr  = dmem_addr;
                memory_wdata = dmem_wdata;
                memory_wstrb = dmem_wstrb;
            end
            default: ;
        endcase
    end

    assign memory_valid = w_fwd_valid && !reset;
    assign imem_ready   = memory_ready && (w_sel == OWN_IMEM) && !reset;
    assign dmem_ready   = memory_ready && (w_sel == OWN_DMEM) && !reset;
    assign imem_rdata   = memory_rdata;
    assign dmem_rdata   = memory_rdata;
    assign dbg_owner    = r_owner;
    assign dbg_scnt     = r_scnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner <= OWN_NONE;
            r_scnt  <= 4'd0;
        end else begin
            case (r_owner)
                OWN_NONE: begin
                    if (w_sel != OWN_NONE) begin
                        // Lock only when the transaction did not finish now.
                        if (!memory_ready) begin
                            r_owner <= w_sel;
                        end
                        // Count dmem wins only while imem is actually waiting.
                        if (w_sel == OWN_DMEM && imem_valid) begin
                            if (r_scnt != 4'hF) begin
                                r_scnt <= r_scnt + 4'd1;
                            end
                        end else begin
                            r_scnt <= 4'd0;
                        end
                    end
                end
                OWN_IMEM: begin
                    if (memory_ready || !imem_valid) begin
                        r_owner <= OWN_NONE;
                    end
                end
                OWN_DMEM: begin
                    if (memory_ready || !dmem_valid) begin
                        r_owner <= OWN_NONE;
                    end
                end
                default: r_owner <= OWN_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid, imem_instr, dmem_valid, dmem_instr;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic [3:0]  imem_wstrb, dmem_wstrb;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        imem_ready, dmem_ready;
    logic        memory_valid, memory_instr, memory_ready;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;
    logic [1:0]  dbg_owner;
    logic [3:0]  dbg_scnt;

    mem_arbiter #(.starve_limit(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready),
        .dbg_owner(dbg_owner), .dbg_scnt(dbg_scnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_busy: requester currently being served across cycles (0 none,
    // 1 imem, 2 dmem). m_streak: dmem wins in a row while imem waited.
    int m_busy = 0, m_streak = 0, m_busy_n, m_streak_n;
    logic [32:0] exp_q[$];

    // Last sampled DUT outputs, for drivers and directed checks.
    logic        s_mv, s_iready, s_dready;
    logic [31:0] s_maddr, s_irdata;
    logic [1:0]  s_owner;
    logic [3:0]  s_scnt;

    task automatic step();
        int          who;
        logic        e_valid, e_instr, e_ir, e_dr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [32:0] got;
        @(negedge clock);
        s_mv = memory_valid; s_maddr = memory_addr; s_iready = imem_ready;
        s_dready = dmem_ready; s_irdata = imem_rdata;
        s_owner = dbg_owner; s_scnt = dbg_scnt;
        check_eq("owner", 32'(dbg_owner), 32'(m_busy));
        check_eq("scnt", 32'(dbg_scnt), 32'(m_streak));
        e_ir = 1'b0; e_dr = 1'b0;
        if (reset) begin
            check_eq("rst_mvalid", 32'(memory_valid), 32'd0);
            check_eq("rst_iready", 32'(imem_ready), 32'd0);
            check_eq("rst_dready", 32'(dmem_ready), 32'd0);
            m_busy_n = 0; m_streak_n = 0;
        end else begin
            if (m_busy != 0)                   who = m_busy;
            else if (imem_valid && dmem_valid) who = (m_streak >= LIMIT) ? 1 : 2;
            else if (imem_valid)               who = 1;
            else if (dmem_valid)               who = 2;
            else                               who = 0;
            e_valid = 0; e_instr = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
            if (who == 1) begin
                e_valid = imem_valid; e_instr = imem_instr; e_addr = imem_addr;
                e_wdata = imem_wdata; e_wstrb = imem_wstrb;
            end else if (who == 2) begin
                e_valid = dmem_valid; e_instr = dmem_instr; e_addr = dmem_addr;
                e_wdata = dmem_wdata; e_wstrb = dmem_wstrb;
            end
            e_ir = memory_ready && who == 1;
            e_dr = memory_ready && who == 2;
            check_eq("mvalid", 32'(memory_valid), 32'(e_valid));
            check_eq("minstr", 32'(memory_instr), 32'(e_instr));
            check_eq("maddr", memory_addr, e_addr);
            check_eq("mwdata", memory_wdata, e_wdata);
            check_eq("mwstrb", 32'(memory_wstrb), 32'(e_wstrb));
            check_eq("iready", 32'(imem_ready), 32'(e_ir));
            check_eq("dready", 32'(dmem_ready), 32'(e_dr));
            check_eq("irdata", imem_rdata, memory_rdata);
            check_eq("drdata", dmem_rdata, memory_rdata);
            m_busy_n = m_busy; m_streak_n = m_streak;
            if (m_busy == 0) begin
                if (who != 0) begin
                    m_busy_n = memory_ready ? 0 : who;
                    if (who == 2 && imem_valid) m_streak_n = (m_streak < 15) ? m_streak + 1 : 15;
                    else                        m_streak_n = 0;
                end
            end else if (memory_ready || !(m_busy == 1 ? imem_valid : dmem_valid)) begin
                m_busy_n = 0;
            end
        end
        // Scoreboard: each completion carries {port, rdata}.
        if (e_ir) exp_q.push_back({1'b0, memory_rdata});
        if (e_dr) exp_q.push_back({1'b1, memory_rdata});
        if (s_iready || s_dready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                got = exp_q.pop_front();
                check_eq("sb_port", 32'(s_dready), 32'(got[32]));
                check_eq("sb_rdata", s_dready ? dmem_rdata : imem_rdata, got[31:0]);
            end
        end
        @(posedge clock);
        #1;
        m_busy = m_busy_n; m_streak = m_streak_n;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        imem_valid = 0; imem_instr = 0; imem_addr = 0; imem_wdata = 0; imem_wstrb = 0;
        dmem_valid = 0; dmem_instr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
        memory_ready = 0; memory_rdata = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
        s_iready = 0; s_dready = 0;
    endtask

    // ---------------- stimulus ----------------
    int  n_d;
    logic got_i, i_skip, d_skip;

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Single fetch: ready after 3 wait cycles.
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h100;
        for (int c = 0; c < 4; c++) begin
            memory_ready = (c == 3);
            memory_rdata = (c == 3) ? 32'h13 : 32'h0;
            step();
            check_eq("fetch_addr", s_maddr, 32'h100);
            check_eq("fetch_iready", 32'(s_iready), 32'(c == 3));
            check_eq("fetch_dready", 32'(s_dready), 32'd0);
        end
        check_eq("fetch_rdata", s_irdata, 32'h13);
        idle();
        step();

        // Contention: dmem first, then imem next cycle.
        do_reset();
        imem_valid = 1; imem_addr = 32'h200;
        dmem_valid = 1; dmem_addr = 32'h8000; dmem_wstrb = 4'hF; dmem_wdata = 32'hDEADBEEF;
        step();
        check_eq("cont_first", s_maddr, 32'h8000);
        memory_ready = 1;
        step();
        check_eq("cont_dready", 32'(s_dready), 32'd1);
        dmem_valid = 0; memory_ready = 0;
        step();
        check_eq("cont_second", s_maddr, 32'h200);
        check_eq("cont_second_v", 32'(s_mv), 32'd1);
        memory_ready = 1;
        step();
        check_eq("cont_iready", 32'(s_iready), 32'd1);
        idle();

        // Starvation: back-to-back single-cycle dmem while imem waits.
        do_reset();
        imem_valid = 1; imem_addr = 32'h300;
        dmem_valid = 1; dmem_addr = 32'h9000;
        memory_ready = 1;
        n_d = 0; got_i = 0;
        for (int c = 0; c < 12 && !got_i; c++) begin
            if (s_dready) dmem_addr = dmem_addr + 32'd4;
            step();
            if (s_dready) n_d++;
            if (s_iready) got_i = 1;
        end
        check_eq("starve_dgrants", n_d, 32'd4);
        check_eq("starve_igrant", 32'(got_i), 32'd1);
        idle();
        step();
        check_eq("starve_scnt", 32'(s_scnt), 32'd0);

        // Lock: dmem held 5 cycles, imem arrives at cycle 2.
        do_reset();
        dmem_valid = 1; dmem_addr = 32'h8000;
        imem_addr = 32'h400;
        for (int c = 0; c < 6; c++) begin
            imem_valid = (c >= 2);
            memory_ready = (c == 5);
            step();
            check_eq("lock_addr", s_maddr, 32'h8000);
            check_eq("lock_iready", 32'(s_iready), 32'd0);
        end
        dmem_valid = 0; memory_ready = 1;
        step();
        check_eq("lock_imem_addr", s_maddr, 32'h400);
        check_eq("lock_imem_ready", 32'(s_iready), 32'd1);
        idle();

        // Reset mid-transaction.
        do_reset();
        imem_valid = 1; imem_addr = 32'h500;
        step();
        step();
        reset = 1;
        step();
        check_eq("rmid_mvalid", 32'(s_mv), 32'd0);
        reset = 0; imem_valid = 0; memory_ready = 1;
        step();
        check_eq("rmid_iready", 32'(s_iready), 32'd0);
        check_eq("rmid_dready", 32'(s_dready), 32'd0);
        check_eq("rmid_owner", 32'(s_owner), 32'd0);
        idle();

        // Abandon: dmem drops valid while locked; imem granted next.
        do_reset();
        dmem_valid = 1; dmem_addr = 32'h8800;
        imem_valid = 1; imem_addr = 32'h600;
        step();
        dmem_valid = 0;
        step();
        check_eq("abandon_mvalid", 32'(s_mv), 32'd0);
        step();
        check_eq("abandon_owner", 32'(s_owner), 32'd0);
        check_eq("abandon_next_v", 32'(s_mv), 32'd1);
        check_eq("abandon_next_a", s_maddr, 32'h600);
        memory_ready = 1;
        step();
        idle();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_skip = 0; d_skip = 0;
            if (imem_valid) begin
                if (s_iready) imem_valid = 0;
                else if ($urandom_range(0, 29) == 0) begin imem_valid = 0; i_skip = 1; end
            end
            if (dmem_valid) begin
                if (s_dready) dmem_valid = 0;
                else if ($urandom_range(0, 19) == 0) begin dmem_valid = 0; d_skip = 1; end
            end
            if (!imem_valid && !i_skip && $urandom_range(0, 3) != 0) begin
                imem_valid = 1; imem_instr = 1'($urandom_range(0, 1));
                imem_addr = $urandom(); imem_wdata = $urandom();
                imem_wstrb = 4'($urandom_range(0, 15));
            end
            if (!dmem_valid && !d_skip && $urandom_range(0, 2) != 0) begin
                dmem_valid = 1; dmem_instr = 1'($urandom_range(0, 1));
                dmem_addr = $urandom(); dmem_wdata = $urandom();
                dmem_wstrb = 4'($urandom_range(0, 15));
            end
            memory_ready = ($urandom_range(0, 2) == 0);
            memory_rdata = $urandom();
            reset = ($urandom_range(0, 149) == 0);
            if (reset) begin imem_valid = 0; dmem_valid = 0; end
            step();
            if (reset) begin s_iready = 0; s_dready = 0; end
        end
        reset = 0;
        idle();
        step();

        check_eq("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
